// File: rtl/perf_counter_bank.sv
// -----------------------------------------------------------------------------
// perf_counter_bank
//
// Bank of CHANNELS independent event counters, WIDTH bits each, for CPU
// performance monitoring (cycles while running, taken branches, jumps,
// syscalls, ...). Each counter either wraps or saturates (SATURATE), keeps
// a sticky overflow flag, and can be copied atomically into a shadow register
// bank. A one-register-deep read port returns the shadow of the selected
// channel to the debug/LED display logic.
//
// Parameters:
//   WIDTH    - counter / shadow / rd_data width
//   CHANNELS - number of channels (1..16)
//   SATURATE - 0: wrap modulo 2^WIDTH, 1: stick at all-ones
//   SELW     - width of rd_sel, 2^SELW >= CHANNELS
//
// Ports:
//   clk      in   1         rising-edge clock
//   clr      in   1         asynchronous active-low reset of all state
//   enable   in   1         CPU run qualifier; counting only while 1
//   events   in   CHANNELS  per-channel event strobes
//   freeze   in   1         holds all counters (snap/read still work)
//   soft_clr in   1         synchronous clear of counters and overflow flags
//   snap     in   1         copy all live counters into the shadow bank
//   rd_sel   in   SELW      channel index for the read port
//   rd_data  out  WIDTH     registered shadow value of the selected channel
//   ovf      out  CHANNELS  sticky per-channel overflow flags
// -----------------------------------------------------------------------------
module perf_counter_bank #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int SATURATE = 0,
  parameter int SELW     = 4
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                enable,
  input  logic [CHANNELS-1:0] events,
  input  logic                freeze,
  input  logic                soft_clr,
  input  logic                snap,
  input  logic [SELW-1:0]     rd_sel,
  output logic [WIDTH-1:0]    rd_data,
  output logic [CHANNELS-1:0] ovf
);

  logic [WIDTH-1:0]    r_cnt    [CHANNELS];
  logic [WIDTH-1:0]    r_shadow [CHANNELS];
  logic [CHANNELS-1:0] r_ovf;
  logic [WIDTH-1:0]    r_rd_data;

  logic [CHANNELS-1:0] w_inc;
  logic [WIDTH-1:0]    w_next   [CHANNELS];
  logic [CHANNELS-1:0] w_hit;
  logic [WIDTH-1:0]    w_rd_mux;

  // One increment step. Returns {overflow_hit, next_count}. In wrap mode the
  // hit is the carry out of the all-ones -> 0 transition; in saturate mode the
  // count holds at all-ones and every further event re-asserts the hit.
  function automatic logic [WIDTH:0] f_step(input logic [WIDTH-1:0] cnt);
    logic [WIDTH:0] sum;
    sum = {1'b0, cnt} + {{WIDTH{1'b0}}, 1'b1};
    if (SATURATE != 0) begin
      if (&cnt) f_step = {1'b1, cnt};
      else      f_step = {1'b0, sum[WIDTH-1:0]};
    end else begin
      f_step = sum;
    end
  endfunction

  // soft_clr has priority over counting, so it also masks the increment.
  assign w_inc = events & {CHANNELS{enable & ~freeze & ~soft_clr}};

  always_comb begin
    w_hit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_next[i] = '0;
      {w_hit[i], w_next[i]} = f_step(r_cnt[i]);
    end
  end

  // Out-of-range selects read back as zero.
  always_comb begin
    w_rd_mux = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (int'(rd_sel) == i) w_rd_mux = r_shadow[i];
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_cnt[i]    <= '0;
        r_shadow[i] <= '0;
      end
      r_ovf     <= '0;
      r_rd_data <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (soft_clr) begin
          r_cnt[i] <= '0;
          r_ovf[i] <= 1'b0;
        end else if (w_inc[i]) begin
          r_cnt[i] <= w_next[i];
          if (w_hit[i]) r_ovf[i] <= 1'b1;
        end
        // Pre-edge counter values: a same-edge increment or soft_clr is not
        // part of the snapshot.
        if (snap) r_shadow[i] <= r_cnt[i];
      end
      r_rd_data <= w_rd_mux;
    end
  end

  assign rd_data = r_rd_data;
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_perf_counter_bank.sv
module tb_perf_counter_bank;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance A: default 32-bit wrap bank.
  logic        a_en, a_frz, a_sc, a_snap;
  logic [3:0]  a_ev, a_sel, a_ovf;
  logic [31:0] a_rd;
  // Instance B: 4-bit wrap bank.
  logic        b_en, b_frz, b_sc, b_snap;
  logic [3:0]  b_ev, b_sel, b_ovf, b_rd;
  // Instance C: 4-bit saturating bank.
  logic        c_en, c_frz, c_sc, c_snap;
  logic [3:0]  c_ev, c_sel, c_ovf, c_rd;

  perf_counter_bank #(.WIDTH(32), .CHANNELS(4), .SATURATE(0), .SELW(4)) dut_a (
    .clk(clk), .clr(clr), .enable(a_en), .events(a_ev), .freeze(a_frz),
    .soft_clr(a_sc), .snap(a_snap), .rd_sel(a_sel), .rd_data(a_rd), .ovf(a_ovf));

  perf_counter_bank #(.WIDTH(4), .CHANNELS(4), .SATURATE(0), .SELW(4)) dut_b (
    .clk(clk), .clr(clr), .enable(b_en), .events(b_ev), .freeze(b_frz),
    .soft_clr(b_sc), .snap(b_snap), .rd_sel(b_sel), .rd_data(b_rd), .ovf(b_ovf));

  perf_counter_bank #(.WIDTH(4), .CHANNELS(4), .SATURATE(1), .SELW(4)) dut_c (
    .clk(clk), .clr(clr), .enable(c_en), .events(c_ev), .freeze(c_frz),
    .soft_clr(c_sc), .snap(c_snap), .rd_sel(c_sel), .rd_data(c_rd), .ovf(c_ovf));

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    {a_en, a_frz, a_sc, a_snap, a_ev, a_sel} = '0;
    {b_en, b_frz, b_sc, b_snap, b_ev, b_sel} = '0;
    {c_en, c_frz, c_sc, c_snap, c_ev, c_sel} = '0;
    #1 clr = 1'b0;
    #1;
    n_checks++;
    if (a_rd !== 32'd0) begin n_fail++; $display("FAIL reset_a_rd: got %0d want 0", a_rd); end
    n_checks++;
    if ({a_ovf, b_ovf, c_ovf} !== 12'd0) begin n_fail++; $display("FAIL reset_ovf: got %h want 000", {a_ovf, b_ovf, c_ovf}); end
    tick();
    tick();
    n_checks++;
    if ({b_rd, c_rd} !== 8'd0) begin n_fail++; $display("FAIL reset_bc_rd: got %h want 00", {b_rd, c_rd}); end
    clr = 1'b1;
    tick();
  endtask

  task automatic test_basic_count();
    a_en = 1'b1; a_ev = 4'b0001;
    repeat (10) tick();
    a_ev = 4'b0000; a_snap = 1'b1; a_sel = 4'd0;
    tick();
    a_snap = 1'b0;
    tick();
    n_checks++;
    if (a_rd !== 32'd10) begin n_fail++; $display("FAIL basic_ch0: got %0d want 10", a_rd); end
    a_sel = 4'd1;
    tick();
    tick();
    n_checks++;
    if (a_rd !== 32'd0) begin n_fail++; $display("FAIL basic_ch1: got %0d want 0", a_rd); end
    n_checks++;
    if (a_ovf !== 4'b0000) begin n_fail++; $display("FAIL basic_ovf: got %b want 0000", a_ovf); end
  endtask

  task automatic test_qualifiers();
    a_sc = 1'b1;
    tick();
    a_sc = 1'b0; a_ev = 4'b1111;
    // Counting cycles 1,2,5,7,8 only -> 5 events per channel.
    for (int c = 1; c <= 8; c++) begin
      a_frz = (c == 3 || c == 4);
      a_en  = (c != 6);
      tick();
    end
    a_ev = 4'b0000; a_frz = 1'b1; a_en = 1'b1; a_snap = 1'b1;
    tick();
    a_snap = 1'b0; a_frz = 1'b0;
    for (int s = 0; s < 4; s++) begin
      a_sel = 4'(s);
      tick();
      n_checks++;
      if (a_rd !== 32'd5) begin n_fail++; $display("FAIL qual_ch%0d: got %0d want 5", s, a_rd); end
    end
    a_sel = 4'd5;
    tick();
    n_checks++;
    if (a_rd !== 32'd0) begin n_fail++; $display("FAIL qual_oob_sel: got %0d want 0", a_rd); end
  endtask

  task automatic test_wrap();
    b_en = 1'b1; b_ev = 4'b0100;
    repeat (15) tick();
    n_checks++;
    if (b_ovf !== 4'b0000) begin n_fail++; $display("FAIL wrap_no_ovf_at_15: got %b want 0000", b_ovf); end
    repeat (2) tick();
    n_checks++;
    if (b_ovf !== 4'b0100) begin n_fail++; $display("FAIL wrap_ovf: got %b want 0100", b_ovf); end
    b_ev = 4'b0000; b_snap = 1'b1; b_sel = 4'd2;
    tick();
    b_snap = 1'b0;
    tick();
    n_checks++;
    if (b_rd !== 4'd1) begin n_fail++; $display("FAIL wrap_cnt: got %0d want 1", b_rd); end
    b_sc = 1'b1;
    tick();
    b_sc = 1'b0;
    n_checks++;
    if (b_ovf !== 4'b0000) begin n_fail++; $display("FAIL wrap_softclr_ovf: got %b want 0000", b_ovf); end
    tick();
    n_checks++;
    if (b_rd !== 4'd1) begin n_fail++; $display("FAIL wrap_shadow_kept: got %0d want 1", b_rd); end
    b_snap = 1'b1;
    tick();
    b_snap = 1'b0;
    tick();
    n_checks++;
    if (b_rd !== 4'd0) begin n_fail++; $display("FAIL wrap_softclr_cnt: got %0d want 0", b_rd); end
  endtask

  task automatic test_saturate();
    c_en = 1'b1; c_ev = 4'b0010; c_sel = 4'd1;
    repeat (15) tick();
    n_checks++;
    if (c_ovf !== 4'b0000) begin n_fail++; $display("FAIL sat_no_ovf_at_15: got %b want 0000", c_ovf); end
    repeat (5) tick();
    n_checks++;
    if (c_ovf !== 4'b0010) begin n_fail++; $display("FAIL sat_ovf: got %b want 0010", c_ovf); end
    c_snap = 1'b1;
    tick();
    c_snap = 1'b0;
    tick();
    n_checks++;
    if (c_rd !== 4'd15) begin n_fail++; $display("FAIL sat_value: got %0d want 15", c_rd); end
    repeat (3) tick();
    c_ev = 4'b0000; c_snap = 1'b1;
    tick();
    c_snap = 1'b0;
    tick();
    n_checks++;
    if (c_rd !== 4'd15) begin n_fail++; $display("FAIL sat_hold: got %0d want 15", c_rd); end
  endtask

  task automatic test_simultaneous();
    a_sc = 1'b1;
    tick();
    a_sc = 1'b0; a_ev = 4'b0001; a_sel = 4'd0;
    repeat (7) tick();
    a_snap = 1'b1; a_sc = 1'b1; a_ev = 4'b0001;
    tick();
    a_snap = 1'b0; a_sc = 1'b0; a_ev = 4'b0000;
    tick();
    n_checks++;
    if (a_rd !== 32'd7) begin n_fail++; $display("FAIL simul_shadow: got %0d want 7", a_rd); end
    a_snap = 1'b1;
    tick();
    a_snap = 1'b0;
    tick();
    n_checks++;
    if (a_rd !== 32'd0) begin n_fail++; $display("FAIL simul_cnt_cleared: got %0d want 0", a_rd); end
  endtask

  task automatic test_async_clr();
    b_sc = 1'b1;
    tick();
    b_sc = 1'b0; b_ev = 4'b0001; b_sel = 4'd0;
    repeat (17) tick();
    b_snap = 1'b1;
    tick();
    b_snap = 1'b0;
    tick();
    n_checks++;
    if ({b_ovf, b_rd} !== {4'b0001, 4'd1}) begin n_fail++; $display("FAIL preclr_state: got ovf=%b rd=%0d want ovf=0001 rd=1", b_ovf, b_rd); end
    // Pulse clr mid-cycle while channel 0 is still counting.
    #2 clr = 1'b0;
    #1;
    n_checks++;
    if (b_ovf !== 4'b0000) begin n_fail++; $display("FAIL async_ovf: got %b want 0000", b_ovf); end
    n_checks++;
    if (b_rd !== 4'd0) begin n_fail++; $display("FAIL async_rd: got %0d want 0", b_rd); end
    b_ev = 4'b0000;
    #1 clr = 1'b1;
    tick();
    b_snap = 1'b1;
    tick();
    b_snap = 1'b0;
    tick();
    n_checks++;
    if (b_rd !== 4'd0) begin n_fail++; $display("FAIL async_cnt_lost: got %0d want 0", b_rd); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_count();
    test_qualifiers();
    test_wrap();
    test_saturate();
    test_simultaneous();
    test_async_clr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/perf_counter_bank.md
# perf_counter_bank

Parametrised event-counter bank that generalises the CPU's fixed total/branch/jump cycle counters into `CHANNELS` independent counters of `WIDTH` bits each. Each counter has a selectable wrap or saturate mode, a sticky overflow flag, and atomic snapshot registers. A registered read port lets the debug/LED display logic select any channel. The bank sits beside the CPU top and takes per-cycle event strobes from it: cycle-while-running, taken branch, jump, syscall, and so on.

## Interface
Parameters:
- `WIDTH`, 32, bit width of every counter, shadow register and `rd_data`.
- `CHANNELS`, 4, number of counter channels (1..16).
- `SATURATE`, 0: 0 = counters wrap modulo 2^WIDTH; 1 = counters stick at all-ones.
- `SELW`, 4, width of `rd_sel`; must satisfy 2^SELW >= CHANNELS.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `clr`  in  1  asynchronous, active-low reset.
- `enable`  in  1  CPU run qualifier (PC enable); counting happens only when 1.
- `event`  in  CHANNELS  per-channel event strobe, sampled each rising edge.
- `freeze`  in  1  holds all counters; has no effect on snapshot or read.
- `soft_clr`  in  1  synchronous clear of counters and overflow flags.
- `snap`  in  1  copies all live counters into the shadow registers.
- `rd_sel`  in  SELW  channel index for the read port.
- `rd_data`  out  WIDTH  registered shadow value of the selected channel.
- `ovf`  out  CHANNELS  sticky per-channel overflow flags.

## Operation
State: `cnt[i]`, `shadow[i]` and `ovf[i]` for each channel, plus the `rd_data` register.

Increment condition for channel i: `inc[i] = event[i] & enable & ~freeze & ~soft_clr`.

Wrap mode (`SATURATE=0`), when `inc[i]`:
- `cnt[i] <= cnt[i] + 1`, modulo 2^WIDTH.
- On the transition all-ones -> 0, `ovf[i] <= 1`.

Saturate mode (`SATURATE=1`), when `inc[i]`:
- If `cnt[i]` is below all-ones, add 1.
- If `cnt[i]` is already all-ones, it stays all-ones and `ovf[i] <= 1`.

`ovf[i]` is sticky. It is cleared only by `soft_clr` or `clr`.

`soft_clr` (priority over counting):
- Every `cnt[i]` goes to 0 and every `ovf[i]` goes to 0 at the edge.
- Shadow registers are untouched.

`snap`:
- Every `shadow[i] <= cnt[i]` at the edge, using the pre-edge value, so all channels are captured in the same cycle.
- An increment on that same edge is excluded from the snapshot.
- A `soft_clr` on that same edge: the snapshot still takes the old values.

Read port:
- `rd_data <= shadow[rd_sel]` every edge.
- If `rd_sel >= CHANNELS`, `rd_data <= 0`.
- Reads never disturb counters.

`freeze` and `enable=0` are equivalent for counting. `snap` and `soft_clr` are still honoured while frozen.

## Timing
- Reset (`clr=0`, asynchronous): all `cnt`, `shadow`, `ovf` and `rd_data` go to 0 immediately. They hold 0 until the first rising edge after `clr` returns to 1.
- Reset asserted mid-count or mid-snapshot: state is lost and goes to 0. No partial snapshot survives.
- Counter latency: an event sampled at edge t is visible in `cnt` after edge t and in `ovf` after edge t.
- Snapshot latency: `snap` at edge t updates `shadow` at edge t. It appears on `rd_data` at edge t+1 if `rd_sel` is stable.
- Read latency: a `rd_sel` change at edge t is reflected in `rd_data` after edge t+1. The read path is one register deep.
- At most one increment per channel per cycle. Channels are fully independent, so simultaneous events on all channels each add 1.
- No handshakes. All control inputs are level-sampled single-cycle strobes. Holding `snap` high re-snapshots every cycle.

## Test plan
- Reset and basic count: `clr` low, check all outputs 0. Release; hold `enable=1`, `event=4'b0001` for 10 cycles; `snap`; `rd_sel=0` -> `rd_data=10` two edges after `snap`. `rd_sel=1` -> 0.
- Qualifiers: `event=4'b1111` for 8 cycles with `freeze=1` on cycles 3-4 and `enable=0` on cycle 6 -> every channel snapshots 5. `rd_sel=5` (out of range) -> `rd_data=0`.
- Wrap mode with `WIDTH=4`: 17 events on channel 2 -> `cnt[2]=1`, `ovf=4'b0100`. Then `soft_clr` -> `cnt=0`, `ovf=0`, and the shadow still holds the prior snapshot.
- Saturate mode with `WIDTH=4`: 20 events on channel 1 -> snapshot 15 and `ovf[1]=1`. Further events leave 15.
- Simultaneous events: `snap`, `soft_clr` and `event[0]` together with `cnt[0]=7` -> shadow 7, `cnt[0]=0` after the edge. Asynchronous `clr` pulse mid-count -> `rd_data` and `ovf` drop to 0 without a clock edge.
